core_feeder: RTL
================

// Module: core_feeder
// PURPOSE
//   Upstream sequencer for the MAC neuron core. Buffers one input vector,
//   then streams it element by element into the core with matching
//   forward/backward strobes, weight index and error term. For forward
//   passes it captures the core's y result and presents it on a
//   valid/ready output port.
// PARAMETERS
//   DEPTH  100  max vector length; equals core weight count
//   IW     7    index width, clog2(DEPTH)
//   DW     16   data width, two's complement
// PORTS
//   clk            in   1   system clock, rising edge
//   rst            in   1   asynchronous reset, active-high
//   in_valid       in   1   input vector beat valid
//   in_ready       out  1   feeder accepts beat
//   in_data        in   DW  vector element
//   in_last        in   1   final element of vector
//   start_fwd      in   1   1-cycle pulse: start forward pass
//   start_bwd      in   1   1-cycle pulse: start backward (update) pass
//   err_in         in   DW  error term, sampled on accepted start_bwd
//   core_rdy       out  1   element presented to core this cycle
//   core_forward   out  1   forward strobe to core
//   core_backward  out  1   backward strobe to core
//   core_x         out  DW  element to core
//   core_e         out  DW  latched error to core
//   core_index     out  IW  weight index to core
//   core_vld       in   1   core y valid
//   core_y         in   DW  core accumulator result
//   out_valid      out  1   captured y available
//   out_data       out  DW  captured y
//   out_ready      in   1   downstream accepts out_data
//   busy           out  1   state != IDLE
//   vec_loaded     out  1   buffer holds a complete vector
// BEHAVIOUR
//   Reset: every output 0; state IDLE; wr_ptr=0; len=0; buffer contents undefined.
//   States: IDLE, LOAD, FWD, BWD, WAIT_Y, OUT.
//   in_ready=1 only in IDLE/LOAD. Accepted beat (in_valid&in_ready) writes
//     buf[wr_ptr], wr_ptr++. First beat accepted in IDLE clears vec_loaded,
//     restarts at wr_ptr=0, enters LOAD.
//   LOAD ends on beat with in_last or at wr_ptr==DEPTH-1: len=wr_ptr+1,
//     vec_loaded=1, wr_ptr=0, -> IDLE. No overflow possible.
//   Starts accepted only in IDLE with vec_loaded=1; otherwise ignored.
//     start_fwd and start_bwd same cycle: forward wins, bwd dropped.
//     start_bwd latches err_in into e_reg.
//   FWD/BWD: registered outputs, first element 1 cycle after start; for i=0..len-1,
//     one per cycle: core_rdy=1, core_index=i, core_x=buf[i], core_forward (FWD)
//     or core_backward+core_e=e_reg (BWD). Strobes drop cycle after i=len-1.
//   FWD -> WAIT_Y; BWD -> IDLE (vec_loaded stays 1; vector reusable).
//   WAIT_Y: waits unbounded for core_vld; captures core_y -> OUT.
//     core_vld outside WAIT_Y ignored.
//   OUT: out_valid=1, out_data stable until out_valid&out_ready; then -> IDLE.
//   Streaming latency: len+1 cycles from start to last strobe deassert.
//   Async rst mid-pass: strobes and out_valid drop immediately; vec_loaded=0.
// CONFIGURATION
//   CORE_FEEDER_PASSCNT_EN defined: adds output pass_cnt [15:0], reset 0,
//     +1 on each OUT handshake and each BWD completion, wraps 0xFFFF->0.
//   Undefined: port and counter absent; all other behaviour identical.
// TESTING
//   Load 3 beats 0x0001,0x0002,0x0003 (last on 3rd) -> vec_loaded=1, len=3.
//   start_fwd -> 3 cycles core_forward=1, core_index 0,1,2, core_x 1,2,3.
//   WAIT_Y, core_vld with core_y=0x1234 -> out_valid=1, out_data=0x1234 held
//     while out_ready=0 for 4 cycles; handshake -> IDLE, busy=0.
//   start_bwd, err_in=0xFFFE -> 3 cycles core_backward=1, core_e=0xFFFE.
//   100 beats, no in_last -> in_ready=0 after beat 100, len=100, index 0..99.
//   start_fwd+start_bwd same cycle -> forward only; rst at index 1 -> all 0.

Source files
------------

// File: rtl/core_feeder_if.sv
// ---------------------------------------------------------------------------
// core_feeder_if
// Bundles the handshake and core-facing signals of core_feeder.
//   slave  : the feeder itself (accepts vector beats and starts, drives the
//            core strobes, presents the captured y result)
//   master : the environment around the feeder (vector source, pass
//            controller, MAC core and result sink)
// Parameters: IW index width, DW data width.
// ---------------------------------------------------------------------------
interface core_feeder_if #(
    parameter int IW = 7,
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          start_fwd;
    logic          start_bwd;
    logic [DW-1:0] err_in;
    logic          core_rdy;
    logic          core_forward;
    logic          core_backward;
    logic [DW-1:0] core_x;
    logic [DW-1:0] core_e;
    logic [IW-1:0] core_index;
    logic          core_vld;
    logic [DW-1:0] core_y;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          vec_loaded;

    modport slave (
        input  in_valid, in_data, in_last, start_fwd, start_bwd, err_in,
               core_vld, core_y, out_ready,
        output in_ready, core_rdy, core_forward, core_backward, core_x,
               core_e, core_index, out_valid, out_data, busy, vec_loaded
    );

    modport master (
        output in_valid, in_data, in_last, start_fwd, start_bwd, err_in,
               core_vld, core_y, out_ready,
        input  in_ready, core_rdy, core_forward, core_backward, core_x,
               core_e, core_index, out_valid, out_data, busy, vec_loaded
    );
endinterface

// File: rtl/core_feeder.sv
// ---------------------------------------------------------------------------
// core_feeder
// Upstream sequencer for the MAC neuron core. Buffers one input vector, then
// streams it element by element into the core with forward or backward
// strobes, weight index and error term. Forward passes capture the core's y
// result and present it on a valid/ready output.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   bus        core_feeder_if.slave: vector input (in_*), pass starts
//              (start_fwd/start_bwd/err_in), core side (core_*), result
//              output (out_*), status (busy, vec_loaded)
//   pass_cnt   [15:0] completed-pass counter, present only when the macro
//              CORE_FEEDER_PASSCNT_EN is defined
// Parameters: DEPTH max vector length, IW index width, DW data width.
// ---------------------------------------------------------------------------
module core_feeder #(
    parameter int DEPTH = 100,
    parameter int IW    = 7,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    core_feeder_if.slave       bus
`ifdef CORE_FEEDER_PASSCNT_EN
    ,
    output logic [15:0]        pass_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FWD    = 3'd2,
        S_BWD    = 3'd3,
        S_WAIT_Y = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t        state_r;
    logic [DW-1:0] vec_mem [DEPTH];
    logic [IW-1:0] wr_ptr_r;
    logic [IW-1:0] last_idx_r;      // vector length minus one
    logic [DW-1:0] e_reg_r;

    logic          in_ready_r;
    logic          core_rdy_r;
    logic          core_forward_r;
    logic          core_backward_r;
    logic [DW-1:0] core_x_r;
    logic [DW-1:0] core_e_r;
    logic [IW-1:0] core_index_r;
    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic          busy_r;
    logic          vec_loaded_r;

    logic          beat_s;
    logic [IW-1:0] beat_idx_s;
    logic          beat_end_s;
    logic          start_ok_s;
    logic          fwd_go_s;
    logic          bwd_go_s;
    logic          last_s;
    logic [IW-1:0] nxt_idx_s;

    // A beat arriving in IDLE always restarts the vector at slot 0.
    assign beat_s     = bus.in_valid & in_ready_r;
    assign beat_idx_s = (state_r == S_IDLE) ? {IW{1'b0}} : wr_ptr_r;
    assign beat_end_s = bus.in_last | (beat_idx_s == IW'(DEPTH - 1));
    // A beat in the same cycle as a start wins: the vector is being replaced.
    assign start_ok_s = (state_r == S_IDLE) & vec_loaded_r & ~beat_s;
    assign fwd_go_s   = start_ok_s & bus.start_fwd;
    assign bwd_go_s   = start_ok_s & ~bus.start_fwd & bus.start_bwd;
    assign last_s     = (core_index_r == last_idx_r);
    assign nxt_idx_s  = core_index_r + IW'(1);

    // Vector buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (beat_s) begin
            vec_mem[beat_idx_s] <= bus.in_data;
        end
    end

    // Main sequencer: state plus every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= S_IDLE;
            wr_ptr_r        <= {IW{1'b0}};
            last_idx_r      <= {IW{1'b0}};
            e_reg_r         <= {DW{1'b0}};
            in_ready_r      <= 1'b0;
            core_rdy_r      <= 1'b0;
            core_forward_r  <= 1'b0;
            core_backward_r <= 1'b0;
            core_x_r        <= {DW{1'b0}};
            core_e_r        <= {DW{1'b0}};
            core_index_r    <= {IW{1'b0}};
            out_valid_r     <= 1'b0;
            out_data_r      <= {DW{1'b0}};
            busy_r          <= 1'b0;
            vec_loaded_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (beat_s && beat_end_s) begin
                        // Single-element vector: complete immediately.
                        last_idx_r   <= {IW{1'b0}};
                        vec_loaded_r <= 1'b1;
                        wr_ptr_r     <= {IW{1'b0}};
                        in_ready_r   <= 1'b0;
                    end else if (beat_s) begin
                        vec_loaded_r <= 1'b0;
                        wr_ptr_r     <= IW'(1);
                        state_r      <= S_LOAD;
                        busy_r       <= 1'b1;
                        in_ready_r   <= 1'b1;
                    end else if (fwd_go_s) begin
                        state_r        <= S_FWD;
                        busy_r         <= 1'b1;
                        in_ready_r     <= 1'b0;
                        core_rdy_r     <= 1'b1;
                        core_forward_r <= 1'b1;
                        core_index_r   <= {IW{1'b0}};
                        core_x_r       <= vec_mem[0];
                    end else if (bwd_go_s) begin
                        state_r         <= S_BWD;
                        busy_r          <= 1'b1;
                        in_ready_r      <= 1'b0;
                        e_reg_r         <= bus.err_in;
                        core_rdy_r      <= 1'b1;
                        core_backward_r <= 1'b1;
                        core_e_r        <= bus.err_in;
                        core_index_r    <= {IW{1'b0}};
                        core_x_r        <= vec_mem[0];
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (beat_s && beat_end_s) begin
                        // One-cycle in_ready bubble marks the vector boundary,
                        // so a held in_valid cannot clobber the fresh vector.
                        last_idx_r   <= wr_ptr_r;
                        vec_loaded_r <= 1'b1;
                        wr_ptr_r     <= {IW{1'b0}};
                        state_r      <= S_IDLE;
                        busy_r       <= 1'b0;
                        in_ready_r   <= 1'b0;
                    end else if (beat_s) begin
                        wr_ptr_r <= wr_ptr_r + IW'(1);
                    end
                end
                S_FWD: begin
                    if (last_s) begin
                        core_rdy_r     <= 1'b0;
                        core_forward_r <= 1'b0;
                        core_index_r   <= {IW{1'b0}};
                        core_x_r       <= {DW{1'b0}};
                        state_r        <= S_WAIT_Y;
                    end else begin
                        core_index_r <= nxt_idx_s;
                        core_x_r     <= vec_mem[nxt_idx_s];
                    end
                end
                S_BWD: begin
                    if (last_s) begin
                        core_rdy_r      <= 1'b0;
                        core_backward_r <= 1'b0;
                        core_index_r    <= {IW{1'b0}};
                        core_x_r        <= {DW{1'b0}};
                        core_e_r        <= {DW{1'b0}};
                        state_r         <= S_IDLE;
                        busy_r          <= 1'b0;
                        in_ready_r      <= 1'b1;
                    end else begin
                        core_index_r <= nxt_idx_s;
                        core_x_r     <= vec_mem[nxt_idx_s];
                        core_e_r     <= e_reg_r;
                    end
                end
                S_WAIT_Y: begin
                    if (bus.core_vld) begin
                        out_data_r  <= bus.core_y;
                        out_valid_r <= 1'b1;
                        state_r     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        out_data_r  <= {DW{1'b0}};
                        state_r     <= S_IDLE;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= S_IDLE;
                    busy_r          <= 1'b0;
                    core_rdy_r      <= 1'b0;
                    core_forward_r  <= 1'b0;
                    core_backward_r <= 1'b0;
                    out_valid_r     <= 1'b0;
                    in_ready_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.core_rdy      = core_rdy_r;
    assign bus.core_forward  = core_forward_r;
    assign bus.core_backward = core_backward_r;
    assign bus.core_x        = core_x_r;
    assign bus.core_e        = core_e_r;
    assign bus.core_index    = core_index_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_data      = out_data_r;
    assign bus.busy          = busy_r;
    assign bus.vec_loaded    = vec_loaded_r;

`ifdef CORE_FEEDER_PASSCNT_EN
    logic [15:0] pass_cnt_r;
    logic        pass_evt_s;

    // A pass completes on a result handshake or at the end of a backward stream.
    assign pass_evt_s = ((state_r == S_OUT) & bus.out_ready) |
                        ((state_r == S_BWD) & last_s);

    // Completed-pass counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_r <= 16'h0000;
        end else if (pass_evt_s) begin
            pass_cnt_r <= pass_cnt_r + 16'h0001;
        end
    end

    assign pass_cnt = pass_cnt_r;
`endif

endmodule
